// File: rtl/i2_stage_pkg.sv
// Shared definitions for the i2 operand stager: word indices, control-word bit positions,
// FSM encoding and the packed frame type.
package i2_stage_pkg;

    localparam int IDX_V30  = 0;
    localparam int IDX_V62  = 1;
    localparam int IDX_V94  = 2;
    localparam int IDX_V126 = 3;
    localparam int IDX_V144 = 4;
    localparam int IDX_V176 = 5;
    localparam int IDX_V188 = 6;
    localparam int IDX_CTRL = 7;

    localparam int CTRL_V63     = 0;
    localparam int CTRL_V64     = 1;
    localparam int CTRL_V127    = 2;
    localparam int CTRL_V128    = 3;
    localparam int CTRL_V129    = 4;
    localparam int CTRL_V130    = 5;
    localparam int CTRL_V178_0  = 6;
    localparam int CTRL_V178_1  = 7;
    localparam int CTRL_V190_0  = 8;
    localparam int CTRL_V190_1  = 9;
    localparam int CTRL_V191_31 = 10;
    localparam int CTRL_V193_0  = 11;
    localparam int CTRL_V193_1  = 12;
    localparam int CTRL_SEL_LSB = 24;

    localparam logic [0:0] S_LOAD    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    typedef enum logic [0:0] {
        LOAD    = S_LOAD,
        PRESENT = S_PRESENT
    } state_e;

    typedef logic [7:0][31:0] frame_t;

    function automatic logic [7:0] word_bit(input logic [2:0] idx);
        word_bit = 8'b1 << idx;
    endfunction

endpackage

// File: rtl/i2_frame_buf.sv
// 8x32 frame register with per-word load mask.
// Latency: write visible the cycle after wr_en; clr empties the mask only.
// Backpressure: none, the caller gates wr_en/clr.
module i2_frame_buf
    import i2_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [31:0] wr_word,
    input  logic        clr,
    output frame_t      frame,
    output logic [7:0]  mask
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame <= '0;
            mask  <= '0;
        end else if (clr) begin
            // Words are kept; only the record of what was loaded is dropped.
            mask <= '0;
        end else if (wr_en) begin
            frame[wr_idx] <= wr_word;
            mask[wr_idx]  <= 1'b1;
        end
    end

endmodule

// File: rtl/i2_operand_stager.sv
// Collects an 8-word operand frame and presents it to the i2 reduction stage.
// Latency: out_valid rises 1 cycle after the write that completes the frame.
// Backpressure: holds frame until out_ready; writes stall in PRESENT unless I2_STAGER_SHADOW_BUF_EN.
module i2_operand_stager
    import i2_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [2:0]                  wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        abort,
    output logic [NUM_WORDS*DATA_W-1:0] frame_q,
    output logic [7:0]                  sel_q,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_WORDS-1:0]        load_mask,
    output logic [CNT_W-1:0]            frame_cnt
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic              hs, abort_eff, wr_en, ld_full_nxt;
    logic [7:0]        ld_mask, ld_mask_nxt;
    frame_t            pres_frame;

    assign out_valid   = (state_q == PRESENT);
    assign hs          = out_valid && out_ready;
    assign wr_en       = wr_valid && wr_ready && !abort_eff;
    assign ld_mask_nxt = abort_eff ? 8'h00 : (ld_mask | (wr_en ? word_bit(wr_addr) : 8'h00));
    assign ld_full_nxt = &ld_mask_nxt;

`ifdef I2_STAGER_SHADOW_BUF_EN
    localparam bit SHADOW_EN = 1'b1;

    logic            pres_sel_q;
    frame_t [1:0]    buf_frame;
    logic [1:0][7:0] buf_mask;

    assign wr_ready  = 1'b1;
    assign abort_eff = abort;

    for (genvar b = 0; b < 2; b++) begin : g_buf
        // The buffer not being presented is always the one being loaded.
        i2_frame_buf u_buf (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en && (pres_sel_q != 1'(b))),
            .wr_idx  (wr_addr),
            .wr_word (wr_data),
            .clr     ((pres_sel_q == 1'(b)) ? hs : abort_eff),
            .frame   (buf_frame[b]),
            .mask    (buf_mask[b])
        );
    end

    assign ld_mask    = buf_mask[~pres_sel_q];
    assign pres_frame = buf_frame[pres_sel_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres_sel_q <= 1'b0;
        end else if (((state_q == LOAD) || hs) && ld_full_nxt) begin
            pres_sel_q <= ~pres_sel_q;
        end
    end
`else
    localparam bit SHADOW_EN = 1'b0;

    logic [7:0] buf_mask;

    assign wr_ready  = (state_q == LOAD);
    assign abort_eff = abort && (state_q == LOAD);

    i2_frame_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (wr_addr),
        .wr_word (wr_data),
        .clr     (abort_eff || hs),
        .frame   (pres_frame),
        .mask    (buf_mask)
    );

    assign ld_mask = buf_mask;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (ld_full_nxt) state_d = PRESENT;
            // A full shadow frame replaces the consumed one without a bubble.
            PRESENT: if (hs) state_d = (SHADOW_EN && ld_full_nxt) ? PRESENT : LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (hs) frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign frame_q   = pres_frame;
    assign sel_q     = pres_frame[IDX_CTRL][CTRL_SEL_LSB +: 8];
    assign load_mask = ld_mask;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_i2_operand_stager.sv
// Directed bench for i2_operand_stager; a monitor checks every consumed frame against a queue.
module tb_i2_operand_stager;
    import i2_stage_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_valid, wr_ready, abort, out_valid, out_ready;
    logic [2:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [255:0] frame_q;
    logic [7:0]   sel_q, load_mask;
    logic [15:0]  frame_cnt;

    typedef struct packed {
        frame_t      f;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vecs = 0;
    int   errs = 0;
    bit   done = 1'b0;

    always #5 clk = ~clk;

    i2_operand_stager dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .abort     (abort),
        .frame_q   (frame_q),
        .sel_q     (sel_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .load_mask (load_mask),
        .frame_cnt (frame_cnt)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic load_frame(input frame_t f);
        for (int i = 0; i < 8; i++) wr(3'(i), f[i]);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Monitor: every handshake seen away from the edge must match the next queued frame.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", {255'd0, out_valid}, 256'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_frame", frame_q, e.f);
                    chk("mon_sel", {248'd0, sel_q}, {248'd0, e.f[7][31:24]});
                    chk("mon_cnt", {240'd0, frame_cnt}, {240'd0, e.cnt});
                end
            end
        end
    end

    initial begin
        frame_t f1, f2, f3, f4, f5, fa, fb;
        logic   exp_rdy;
        for (int i = 0; i < 8; i++) begin
            f1[i] = 32'h1 << i;
            f2[i] = 32'h1111_1111 * (i + 1);
            f3[i] = 32'h3000_0000 + i;
            f4[i] = 32'h4400_0000 | (i << 8);
            f5[i] = 32'h0101_0101 * i;
            fa[i] = 32'hA000_0000 + i;
            fb[i] = 32'hB000_0000 + i;
        end
        f2[7] = 32'hC000_0001;
        f3[2] = 32'h0000_5555;

        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
        chk("rst_load_mask", {248'd0, load_mask}, 256'd0);
        chk("rst_frame_q", frame_q, 256'd0);
        chk("rst_frame_cnt", {240'd0, frame_cnt}, 256'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_wr_ready", {255'd0, wr_ready}, 256'd1);

        // Frame 1: one-hot words, out_valid exactly one cycle after the control word.
        for (int i = 0; i < 7; i++) wr(3'(i), f1[i]);
        chk("f1_valid_early", {255'd0, out_valid}, 256'd0);
        chk("f1_mask_7f", {248'd0, load_mask}, {248'd0, 8'h7F});
        wr(3'd7, f1[7]);
        exp_q.push_back('{f: f1, cnt: 16'd0});
        chk("f1_valid", {255'd0, out_valid}, 256'd1);
        chk("f1_mask_ff", {248'd0, load_mask}, {248'd0, 8'hFF});
        chk("f1_word3", {224'd0, frame_q[127:96]}, {224'd0, 32'h8});

`ifdef I2_STAGER_SHADOW_BUF_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
        wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 32'hDEAD_BEEF;
`endif
        repeat (10) @(posedge clk);
        #1;
        chk("hold_frame", frame_q, f1);
        chk("hold_wr_ready", {255'd0, wr_ready}, {255'd0, exp_rdy});
        chk("hold_valid", {255'd0, out_valid}, 256'd1);
        wr_valid = 1'b0;
        consume();
        chk("f1_cnt", {240'd0, frame_cnt}, {240'd0, 16'd1});
        chk("f1_rdy_after", {255'd0, wr_ready}, 256'd1);
        chk("f1_valid_after", {255'd0, out_valid}, 256'd0);
        chk("f1_mask_clr", {248'd0, load_mask}, 256'd0);

        // Frame 2: control word select byte and V63.
        load_frame(f2);
        exp_q.push_back('{f: f2, cnt: 16'd1});
        chk("f2_sel", {248'd0, sel_q}, {248'd0, 8'hC0});
        chk("f2_v63", {255'd0, frame_q[224]}, 256'd1);
        consume();

        // Frame 3: rewriting index 2 does not advance completion.
        wr(3'd2, 32'h0000_AAAA);
        wr(3'd2, 32'h0000_5555);
        for (int i = 0; i < 7; i++) if (i != 2) wr(3'(i), f3[i]);
        chk("f3_mask_7f", {248'd0, load_mask}, {248'd0, 8'h7F});
        chk("f3_valid_early", {255'd0, out_valid}, 256'd0);
        wr(3'd7, f3[7]);
        exp_q.push_back('{f: f3, cnt: 16'd2});
        chk("f3_valid", {255'd0, out_valid}, 256'd1);
        chk("f3_word2", {224'd0, frame_q[95:64]}, {224'd0, 32'h5555});
        consume();

        // Abort wins over a simultaneous write.
        for (int i = 0; i < 5; i++) wr(3'(i), 32'hBAD0_0000 + i);
        chk("ab_mask_pre", {248'd0, load_mask}, {248'd0, 8'h1F});
        abort = 1'b1;
        wr(3'd5, 32'hFFFF_FFFF);
        abort = 1'b0;
        chk("ab_mask", {248'd0, load_mask}, 256'd0);
        chk("ab_valid", {255'd0, out_valid}, 256'd0);
        load_frame(f4);
        exp_q.push_back('{f: f4, cnt: 16'd3});
        chk("f4_valid", {255'd0, out_valid}, 256'd1);
        consume();

        // Counter wrap.
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_cnt_q;
        @(posedge clk); #1;
        chk("wrap_pre", {240'd0, frame_cnt}, {240'd0, 16'hFFFF});
        load_frame(f5);
        exp_q.push_back('{f: f5, cnt: 16'hFFFF});
        consume();
        chk("wrap_cnt", {240'd0, frame_cnt}, 256'd0);

`ifdef I2_STAGER_SHADOW_BUF_EN
        // Back-to-back: B loads behind A and replaces it on the handshake.
        load_frame(fa);
        exp_q.push_back('{f: fa, cnt: 16'd0});
        load_frame(fb);
        exp_q.push_back('{f: fb, cnt: 16'd1});
        chk("sh_hold_a", frame_q, fa);
        chk("sh_mask_b", {248'd0, load_mask}, {248'd0, 8'hFF});
        consume();
        chk("sh_valid", {255'd0, out_valid}, 256'd1);
        chk("sh_frame_b", frame_q, fb);
        chk("sh_cnt", {240'd0, frame_cnt}, {240'd0, 16'd1});
        consume();
        chk("sh_drain", {255'd0, out_valid}, 256'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 256'(exp_q.size()), 256'd0);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
